regwb_ctrl: RTL and testbench

//  Write-back initiator for the 16x32 register file (r15 = PC): sole driver of its we/wa/wd/ib/bv/bl.

---
 rtl/regwb_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regwb_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_ctrl.sv
// ----------------------------------------------------------------------------
// regwb_ctrl
//  Write-back initiator for the 16x32 register file (r15 = PC). It is the only
//  driver of the register file write port (we/wa/wd) and of the PC branch
//  port (ib/bv/bl).
//
//  Results from the load unit, the ALU and the branch unit (link writes) go
//  into a small in-order FIFO. At most one write is issued per cycle. An
//  entry accepted while the FIFO is empty is issued at the same edge
//  (bypass), so we rises one cycle after the handshake. A write to r15 is
//  never issued in the same cycle as ib. If they clash, the r15 write stays at
//  the head for one cycle and nothing behind it may pass.
//
//  Handshake rule for all three inputs: a transfer happens on the rising
//  edge where valid & ready are both high. ready is combinational from the
//  registered FIFO count and the other valids. It never depends on its own
//  valid.
//
//  Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ld_valid/ld_ready          load result handshake
//   ld_wa, ld_wd, ld_byte      load destination, data, byte-load (zero-extend)
//   alu_valid/alu_ready        ALU result handshake
//   alu_wa, alu_wd             ALU destination and data
//   br_valid/br_ready          taken-branch handshake
//   br_target, br_link, br_pc  target, with-link flag, branch address
//   we, wa, wd                 registered register file write port
//   ib, bv, bl                 registered branch strobe, value, link flag
//   pend_mask                  registered per-register "write outstanding"
// ----------------------------------------------------------------------------
module regwb_ctrl #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] LINK_REG = 4'd14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_wa,
    input  logic [31:0] ld_wd,
    input  logic        ld_byte,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_wa,
    input  logic [31:0] alu_wd,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [31:0] br_target,
    input  logic        br_link,
    input  logic [31:0] br_pc,
    output logic        we,
    output logic [3:0]  wa,
    output logic [31:0] wd,
    output logic        ib,
    output logic [31:0] bv,
    output logic        bl,
    output logic [15:0] pend_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    mem_wa [DEPTH];
    logic [31:0]   mem_wd [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic          full, empty, link_block;
    logic          br_fire, link_fire, ld_fire, alu_fire;
    logic          enq_v;
    logic [3:0]    enq_wa;
    logic [31:0]   enq_wd;
    logic          cand_v;
    logic [3:0]    cand_wa;
    logic [31:0]   cand_wd;
    logic          issue, bypass, push, pop;
    logic [15:0]   pend_next;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign link_block = br_valid & br_link;

    // A link branch needs a FIFO slot for the return address, a plain branch
    // does not, but it still waits while the FIFO is full so that a stuck r15
    // head drains before the PC moves again.
    assign br_ready  = br_link ? (count <= CW'(DEPTH - 2)) : (count <= CW'(DEPTH - 1));
    assign ld_ready  = !full & !link_block;
    assign alu_ready = !full & !ld_valid & !link_block;

    assign br_fire   = br_valid & br_ready;
    assign link_fire = br_fire & br_link;
    assign ld_fire   = ld_valid & ld_ready;
    assign alu_fire  = alu_valid & alu_ready;
    assign enq_v     = link_fire | ld_fire | alu_fire;

    // The readies are mutually exclusive already. The priority order here
    // only makes the mux shape explicit.
    always_comb begin
        enq_wa = alu_wa;
        enq_wd = alu_wd;
        if (link_fire) begin
            enq_wa = LINK_REG;
            enq_wd = br_pc + 32'd4;
        end else if (ld_fire) begin
            enq_wa = ld_wa;
            enq_wd = ld_byte ? {24'b0, ld_wd[7:0]} : ld_wd;
        end
    end

    // Issue candidate: with an empty FIFO, the entry arriving now; otherwise
    // the head. A candidate targeting r15 waits while a branch fires.
    assign cand_v  = !empty | enq_v;
    assign cand_wa = empty ? enq_wa : mem_wa[rd_ptr];
    assign cand_wd = empty ? enq_wd : mem_wd[rd_ptr];
    assign issue   = cand_v & !(br_fire & (cand_wa == 4'd15));
    assign bypass  = empty & issue;
    assign push    = enq_v & !bypass;
    assign pop     = issue & !empty;

    // Mask of everything still outstanding after this edge: surviving FIFO
    // entries, the entry being pushed, and the entry being issued.
    always_comb begin
        pend_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && !((i == 0) && pop)) begin
                pend_next = pend_next | (16'd1 << mem_wa[rd_ptr + AW'(i)]);
            end
        end
        if (push) pend_next = pend_next | (16'd1 << enq_wa);
        if (issue) pend_next = pend_next | (16'd1 << cand_wa);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_wa[wr_ptr] <= enq_wa;
            mem_wd[wr_ptr] <= enq_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            we        <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            ib        <= 1'b0;
            bv        <= '0;
            bl        <= 1'b0;
            pend_mask <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);

            we <= issue;
            if (issue) begin
                wa <= cand_wa;
                wd <= cand_wd;
            end

            ib <= br_fire;
            bl <= link_fire;
            if (br_fire) bv <= br_target;

            pend_mask <= pend_next;
        end
    end

endmodule

// File: tb/tb_regwb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regwb_ctrl
//  Directed scenarios plus a randomized run, all checked against a queue
//  model: accepted results go to the back of exp_q. Each edge the front entry
//  retires unless it targets r15 while a branch fires.
// ----------------------------------------------------------------------------
module tb_regwb_ctrl;

    localparam int         DEPTH    = 4;
    localparam logic [3:0] LINK_REG = 4'd14;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_byte;
    logic [3:0]  ld_wa;
    logic [31:0] ld_wd;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        br_valid, br_ready, br_link;
    logic [31:0] br_target, br_pc;
    logic        we, ib, bl;
    logic [3:0]  wa;
    logic [31:0] wd, bv;
    logic [15:0] pend_mask;

    regwb_ctrl #(.DEPTH(DEPTH), .LINK_REG(LINK_REG)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd), .ld_byte(ld_byte),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .br_valid(br_valid), .br_ready(br_ready), .br_target(br_target), .br_link(br_link), .br_pc(br_pc),
        .we(we), .wa(wa), .wd(wd), .ib(ib), .bv(bv), .bl(bl), .pend_mask(pend_mask)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] exp_q[$];   // {wa, wd} in enqueue order
    logic        exp_we, exp_ib, exp_bl;
    logic [3:0]  exp_wa;
    logic [31:0] exp_wd, exp_bv;
    logic [15:0] exp_pend;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
        exp_ib = 1'b0; exp_bl = 1'b0; exp_bv = '0; exp_pend = '0;
    endtask

    task automatic check_outputs();
        check("we", 32'(we), 32'(exp_we));
        if (exp_we) begin
            check("wa", 32'(wa), 32'(exp_wa));
            check("wd", wd, exp_wd);
        end
        check("ib", 32'(ib), 32'(exp_ib));
        check("bl", 32'(bl), 32'(exp_bl));
        check("bv", bv, exp_bv);
        check("pend_mask", 32'(pend_mask), 32'(exp_pend));
    endtask

    // ---------------- driver ----------------
    task automatic idle();
        ld_valid = 0; ld_byte = 0; ld_wa = 0; ld_wd = 0;
        alu_valid = 0; alu_wa = 0; alu_wd = 0;
        br_valid = 0; br_link = 0; br_target = 0; br_pc = 0;
    endtask

    // Called at a negedge with inputs already set. It checks the readies,
    // advances the model across the next posedge, and checks the outputs at
    // the following negedge.
    task automatic step();
        int          sz;
        logic        m_full, e_br, e_ld, e_alu, brf;
        logic [35:0] ent;
        #1;
        sz     = exp_q.size();
        m_full = (sz == DEPTH);
        e_br   = br_link ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1);
        e_ld   = !m_full && !(br_valid && br_link);
        e_alu  = !m_full && !ld_valid && !(br_valid && br_link);
        check("br_ready", 32'(br_ready), 32'(e_br));
        check("ld_ready", 32'(ld_ready), 32'(e_ld));
        check("alu_ready", 32'(alu_ready), 32'(e_alu));

        brf = br_valid && e_br;
        if (brf && br_link)          exp_q.push_back({LINK_REG, br_pc + 32'd4});
        else if (ld_valid && e_ld)   exp_q.push_back({ld_wa, ld_byte ? {24'b0, ld_wd[7:0]} : ld_wd});
        else if (alu_valid && e_alu) exp_q.push_back({alu_wa, alu_wd});

        exp_we = 1'b0;
        if (exp_q.size() > 0 && !(brf && exp_q[0][35:32] == 4'd15)) begin
            ent    = exp_q.pop_front();
            exp_we = 1'b1;
            exp_wa = ent[35:32];
            exp_wd = ent[31:0];
        end
        exp_ib = brf;
        exp_bl = brf && br_link;
        if (brf) exp_bv = br_target;
        exp_pend = '0;
        foreach (exp_q[i]) exp_pend[exp_q[i][35:32]] = 1'b1;
        if (exp_we) exp_pend[exp_wa] = 1'b1;

        @(negedge clk);
        check_outputs();
    endtask

    task automatic branch(input logic link, input logic [31:0] tgt, input logic [31:0] pc);
        br_valid = 1; br_link = link; br_target = tgt; br_pc = pc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Bypass: ALU write to an empty FIFO appears on the next cycle.
        alu_valid = 1; alu_wa = 4'd3; alu_wd = 32'hDEADBEEF;
        step();
        check("bypass_wd", wd, 32'hDEADBEEF);
        check("bypass_pend", 32'(pend_mask), 32'h0000_0008);
        idle(); step();

        // Byte load zero-extends.
        ld_valid = 1; ld_byte = 1; ld_wa = 4'd5; ld_wd = 32'h12345678;
        step();
        check("ldrb_wd", wd, 32'h00000078);
        idle(); step();

        // Branch with link, then a link value that wraps.
        branch(1, 32'h200, 32'h100);
        step();
        check("bl_wd", wd, 32'h104);
        idle(); step();
        branch(1, 32'h300, 32'hFFFFFFFC);
        step();
        check("bl_wrap_wd", wd, 32'h0);
        idle(); step();

        // PC clash: r15 load with a plain branch, then another branch while
        // the r15 write is at the head, with an ALU write queued behind it.
        ld_valid = 1; ld_wa = 4'd15; ld_wd = 32'h40;
        branch(0, 32'h80, 32'h0);
        step();
        check("clash_we", 32'(we), 32'd0);
        idle(); branch(0, 32'h90, 32'h4);
        alu_valid = 1; alu_wa = 4'd2; alu_wd = 32'h22;
        step();
        idle(); step();
        check("clash_r15_wa", 32'(wa), 32'd15);
        idle(); step(); step();

        // Back-pressure to full: stuck r15 head, load beats ALU every cycle.
        ld_valid = 1; ld_wa = 4'd15; ld_wd = 32'h44;
        branch(0, 32'hA0, 32'h8);
        step();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_wa = 4'd1; ld_wd = 32'h100 + 32'(i);
            alu_valid = 1; alu_wa = 4'd2; alu_wd = 32'h200 + 32'(i);
            branch(0, 32'hB0 + 32'(i), 32'hC);
            step();
        end
        ld_valid = 0; br_valid = 0;
        for (int i = 0; i < 6; i++) step();
        idle();

        // Reset mid-stream: fill with a stuck r15 head and three ALU writes.
        ld_valid = 1; ld_wa = 4'd15; ld_wd = 32'h48;
        branch(0, 32'hC0, 32'h10);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_wa = 4'(6 + i); alu_wd = 32'h600 + 32'(i);
            branch(0, 32'hD0, 32'h14);
            step();
        end
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_we", 32'(we), 32'd0);
        check("rst_ib", 32'(ib), 32'd0);
        check("rst_pend", 32'(pend_mask), 32'd0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        step(); step();

        // Randomized traffic, biased toward r15 writes and branches so the
        // FIFO fills and drains repeatedly.
        for (int n = 0; n < 800; n++) begin
            ld_valid  = ($urandom_range(0, 99) < 45);
            ld_byte   = $urandom_range(0, 1);
            ld_wa     = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            ld_wd     = $urandom;
            alu_valid = ($urandom_range(0, 99) < 55);
            alu_wa    = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            alu_wd    = $urandom;
            br_valid  = ($urandom_range(0, 99) < 40);
            br_link   = ($urandom_range(0, 99) < 30);
            br_target = $urandom;
            br_pc     = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
            step();
        end
        idle();
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
